// File: rtl/ntt_arbiter.sv
// Round-robin arbiter sharing one NTT core between two requesters, one whole polynomial job at a time.
// One cycle of grant latency from IDLE, then zero-latency pass-through both ways; ready/valid pass straight through.
module ntt_arbiter #(
  parameter int N    = 8,
  parameter int logN = 3,
  parameter int logq = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            r0_in_valid,
  input  logic [logq-1:0] r0_poly_in,
  output logic            r0_in_ready,
  output logic            r0_out_valid,
  output logic [logq-1:0] r0_poly_out,
  input  logic            r0_out_ready,
  input  logic            r1_in_valid,
  input  logic [logq-1:0] r1_poly_in,
  output logic            r1_in_ready,
  output logic            r1_out_valid,
  output logic [logq-1:0] r1_poly_out,
  input  logic            r1_out_ready,
  output logic            core_in_valid,
  output logic [logq-1:0] core_poly_in,
  input  logic            core_in_ready,
  input  logic            core_out_valid,
  input  logic [logq-1:0] core_poly_out,
  output logic            core_out_ready,
  output logic            busy,
  output logic            owner,
  output logic [15:0]     jobs_done
);

  localparam logic [logN-1:0] LAST_BEAT = logN'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UNLOAD
  } state_t;

  state_t          state;
  state_t          state_d;
  logic            owner_d;
  logic            last_grant;
  logic            last_grant_d;
  logic [logN-1:0] cnt;
  logic [logN-1:0] cnt_d;
  logic [15:0]     jobs_done_d;

  logic            sel_in_valid;
  logic [logq-1:0] sel_poly_in;
  logic            sel_out_ready;

  assign sel_in_valid  = owner ? r1_in_valid  : r0_in_valid;
  assign sel_poly_in   = owner ? r1_poly_in   : r0_poly_in;
  assign sel_out_ready = owner ? r1_out_ready : r0_out_ready;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      jobs_done  <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_grant_d;
      cnt        <= cnt_d;
      jobs_done  <= jobs_done_d;
    end
  end

  always_comb begin
    state_d        = state;
    owner_d        = owner;
    last_grant_d   = last_grant;
    cnt_d          = cnt;
    jobs_done_d    = jobs_done;
    r0_in_ready    = 1'b0;
    r1_in_ready    = 1'b0;
    r0_out_valid   = 1'b0;
    r1_out_valid   = 1'b0;
    r0_poly_out    = '0;
    r1_poly_out    = '0;
    core_in_valid  = 1'b0;
    core_poly_in   = '0;
    core_out_ready = 1'b0;

    case (state)
      IDLE: begin
        if (r0_in_valid || r1_in_valid) begin
          // On a tie the requester that did not own the previous job wins.
          owner_d = (r0_in_valid && r1_in_valid) ? ~last_grant : r1_in_valid;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        core_in_valid = sel_in_valid;
        core_poly_in  = sel_poly_in;
        r0_in_ready   = ~owner & core_in_ready;
        r1_in_ready   = owner & core_in_ready;
        if (sel_in_valid && core_in_ready) begin
          cnt_d = cnt + 1'b1;
          if (cnt == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = UNLOAD;
          end
        end
      end

      UNLOAD: begin
        // Core compute latency is absorbed here; there is deliberately no timeout.
        r0_out_valid   = ~owner & core_out_valid;
        r1_out_valid   = owner & core_out_valid;
        r0_poly_out    = owner ? '0 : core_poly_out;
        r1_poly_out    = owner ? core_poly_out : '0;
        core_out_ready = sel_out_ready;
        if (core_out_valid && sel_out_ready) begin
          cnt_d = cnt + 1'b1;
          if (cnt == LAST_BEAT) begin
            cnt_d        = '0;
            last_grant_d = owner;
            jobs_done_d  = jobs_done + 16'd1;
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ntt_arbiter.sv
// Bench for ntt_arbiter: randomized requesters and core model, scoreboard queues filled at issue time.
module tb_ntt_arbiter;
  localparam int N    = 8;
  localparam int LOGN = 3;
  localparam int LOGQ = 5;

  typedef logic [N*LOGQ-1:0] poly_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      in_v;
  logic [LOGQ-1:0] in_d [2];
  logic [1:0]      out_r;
  logic            core_in_ready;
  logic            core_out_valid;
  logic [LOGQ-1:0] core_poly_out;
  wire  [1:0]      in_r;
  wire  [1:0]      out_v;
  wire  [LOGQ-1:0] out_d0;
  wire  [LOGQ-1:0] out_d1;
  wire             core_in_valid;
  wire  [LOGQ-1:0] core_poly_in;
  wire             core_out_ready;
  wire             busy;
  wire             owner;
  wire  [15:0]     jobs_done;

  ntt_arbiter #(.N(N), .logN(LOGN), .logq(LOGQ)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_in_valid(in_v[0]), .r0_poly_in(in_d[0]), .r0_in_ready(in_r[0]),
    .r0_out_valid(out_v[0]), .r0_poly_out(out_d0), .r0_out_ready(out_r[0]),
    .r1_in_valid(in_v[1]), .r1_poly_in(in_d[1]), .r1_in_ready(in_r[1]),
    .r1_out_valid(out_v[1]), .r1_poly_out(out_d1), .r1_out_ready(out_r[1]),
    .core_in_valid(core_in_valid), .core_poly_in(core_poly_in), .core_in_ready(core_in_ready),
    .core_out_valid(core_out_valid), .core_poly_out(core_poly_out), .core_out_ready(core_out_ready),
    .busy(busy), .owner(owner), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Stimulus and scoreboard state
  poly_t           job_q [2][$];
  logic [LOGQ-1:0] exp_core_q [$];
  logic [LOGQ-1:0] exp_out_q [2][$];
  int              checks = 0;
  int              errors = 0;
  int              m_jobs = 0;
  logic            m_last = 1'b1;
  bit              bp_mode = 0;
  bit              gap_mode = 0;
  bit              rand_gap = 0;
  int              core_lat = -1;
  int              cstate = 0;
  bit              have [2];
  int              drv_idx [2];

  // Reference core transform: output i is a scaled, reversed input plus its index.
  function automatic logic [LOGQ-1:0] xf(input poly_t p, input int i);
    logic [LOGQ-1:0] c;
    c = p[(N-1-i)*LOGQ +: LOGQ];
    return LOGQ'(c * 3 + i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int g, input poly_t p, input bit full);
    job_q[g].push_back(p);
    for (int i = 0; i < N; i++) exp_core_q.push_back(p[i*LOGQ +: LOGQ]);
    if (full) begin
      for (int i = 0; i < N; i++) exp_out_q[g].push_back(xf(p, i));
      m_last = g[0];
      m_jobs++;
    end
  endtask

  task automatic issue_rand(input int g);
    poly_t p;
    for (int i = 0; i < N; i++) p[i*LOGQ +: LOGQ] = LOGQ'($urandom);
    issue(g, p, 1'b1);
  endtask

  task automatic clear_queues();
    job_q[0].delete();
    job_q[1].delete();
    exp_core_q.delete();
    exp_out_q[0].delete();
    exp_out_q[1].delete();
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    clear_queues();
    m_last = 1'b1;
    m_jobs = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      done = !busy && !have[0] && !have[1] && job_q[0].size() == 0 && job_q[1].size() == 0 &&
             exp_core_q.size() == 0 && exp_out_q[0].size() == 0 && exp_out_q[1].size() == 0;
    end
    chk("wait_idle_done", done, 1);
  endtask

  // Requester drivers and result sinks
  initial begin
    bit tog;
    poly_t cur [2];
    int gap [2];
    tog = 0;
    in_v = '0; in_d[0] = '0; in_d[1] = '0; out_r = '0;
    for (int g = 0; g < 2; g++) begin have[g] = 0; drv_idx[g] = 0; gap[g] = 0; end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!reset_n) have[g] = 0;
        else if (have[g] && in_v[g] && in_r[g]) begin
          drv_idx[g]++;
          if (drv_idx[g] == N) have[g] = 0;
          else if (gap_mode && drv_idx[g] % 3 == 0) gap[g] = 2;
        end
      end
      @(posedge clk);
      #1;
      tog = ~tog;
      for (int g = 0; g < 2; g++) begin
        if (!have[g] && reset_n && job_q[g].size() > 0) begin
          cur[g] = job_q[g].pop_front();
          have[g] = 1; drv_idx[g] = 0; gap[g] = 0;
        end
        if (gap[g] > 0) begin
          in_v[g] = 1'b0;
          gap[g]--;
        end else if (have[g] && drv_idx[g] > 0 && rand_gap && $urandom_range(0, 3) == 0) in_v[g] = 1'b0;
        else in_v[g] = have[g];
        in_d[g] = in_v[g] ? cur[g][drv_idx[g]*LOGQ +: LOGQ] : '0;
        out_r[g] = bp_mode ? tog : ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Core model: collect N, wait, emit N transformed coefficients
  initial begin
    poly_t buf_in;
    int n, wcnt;
    n = 0; wcnt = 0; buf_in = '0;
    core_in_ready = 1'b0; core_out_valid = 1'b0; core_poly_out = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cstate = 0; n = 0;
      end else begin
        case (cstate)
          0: if (core_in_valid && core_in_ready) begin
               buf_in[n*LOGQ +: LOGQ] = core_poly_in;
               n++;
               if (n == N) begin
                 n = 0; cstate = 1;
                 wcnt = (core_lat < 0) ? $urandom_range(0, 5) : core_lat;
               end
             end
          1: if (wcnt == 0) cstate = 2; else wcnt--;
          default: if (core_out_valid && core_out_ready) begin
               n++;
               if (n == N) begin n = 0; cstate = 0; end
             end
        endcase
      end
      @(posedge clk);
      #1;
      core_in_ready  = reset_n && cstate == 0 && $urandom_range(0, 3) != 0;
      core_out_valid = cstate == 2 && $urandom_range(0, 3) != 0;
      core_poly_out  = (cstate == 2) ? xf(buf_in, n) : '0;
    end
  end

  // Monitor: pops scoreboard on every handshake, plus per-cycle invariants
  initial begin
    logic [LOGQ-1:0] od;
    string nm;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (core_in_valid && core_in_ready) begin
          chk("core_in_pending", exp_core_q.size() > 0, 1);
          if (exp_core_q.size() > 0) chk("core_in_data", core_poly_in, exp_core_q.pop_front());
        end
        for (int g = 0; g < 2; g++) begin
          od = (g == 0) ? out_d0 : out_d1;
          nm = (g == 0) ? "r0_out" : "r1_out";
          if (out_v[g]) begin
            chk({nm, "_pending"}, exp_out_q[g].size() > 0, 1);
            if (out_r[g] && exp_out_q[g].size() > 0) chk({nm, "_data"}, od, exp_out_q[g].pop_front());
          end
        end
        if (!busy) chk("idle_quiet", {in_r, out_v, core_in_valid, core_out_ready}, 0);
        chk("exclusive", (in_r == 2'b11) || (out_v == 2'b11), 0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    poly_t p;
    bit seen;
    int mode, k;

    reset_dut();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_core_in_valid", core_in_valid, 0);
    chk("rst_core_poly_in", core_poly_in, 0);
    chk("rst_core_out_ready", core_out_ready, 0);
    chk("rst_in_ready", in_r, 0);
    chk("rst_out_valid", out_v, 0);

    // Single job 1..N from r0, valid held high
    p = '0;
    for (int i = 0; i < N; i++) p[i*LOGQ +: LOGQ] = LOGQ'(i + 1);
    issue(0, p, 1'b1);
    wait_idle(2000);
    chk("single_jobs", jobs_done, 1);
    chk("single_busy", busy, 0);
    chk("single_owner", owner, 0);

    // Both requesting from reset: 0,1,0,1
    reset_dut();
    issue_rand(0); issue_rand(1); issue_rand(0); issue_rand(1);
    wait_idle(4000);
    chk("simul_jobs", jobs_done, 4);
    chk("simul_owner", owner, 1);

    // Output ready toggling, 2-cycle input gaps every 3rd beat
    bp_mode = 1; gap_mode = 1;
    issue_rand(0); issue_rand(1); issue_rand(0);
    wait_idle(4000);
    chk("bp_jobs", jobs_done, 16'(m_jobs));
    bp_mode = 0; gap_mode = 0; rand_gap = 1;

    // Random rounds: one requester alone or both contending
    for (int r = 0; r < 25; r++) begin
      mode = $urandom_range(0, 2);
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) issue_rand(mode == 2 ? int'(~m_last) : mode);
      wait_idle(4000);
      chk("rand_owner", owner, m_last);
      chk("rand_jobs", jobs_done, 16'(m_jobs));
    end

    // Slow core: arbiter must hold in UNLOAD without granting anything
    rand_gap = 0; core_lat = 40;
    issue_rand(int'(~m_last)); issue_rand(int'(~m_last));
    seen = 0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      seen = (cstate == 1);
    end
    chk("late_core_waiting", seen, 1);
    for (int t = 0; t < 35; t++) begin
      @(negedge clk);
      chk("late_busy", busy, 1);
      chk("late_in_ready", in_r, 0);
      chk("late_out_valid", out_v, 0);
    end
    wait_idle(4000);
    chk("late_jobs", jobs_done, 16'(m_jobs));
    core_lat = -1;

    // Reset after 4 of N inputs from r1
    for (int i = 0; i < N; i++) p[i*LOGQ +: LOGQ] = LOGQ'($urandom);
    issue(1, p, 1'b0);
    seen = 0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      seen = have[1] && drv_idx[1] >= 4;
    end
    chk("midload_reached", seen, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_owner", owner, 0);
    chk("arst_jobs", jobs_done, 0);
    chk("arst_in_ready", in_r, 0);
    chk("arst_out_valid", out_v, 0);
    chk("arst_core_in", {core_in_valid, core_poly_in}, 0);
    chk("arst_core_out_ready", core_out_ready, 0);
    chk("arst_poly_out", {out_d0, out_d1}, 0);
    repeat (3) @(posedge clk);
    clear_queues();
    m_last = 1'b1;
    m_jobs = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_jobs", jobs_done, 0);
    issue_rand(0); issue_rand(1);
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = busy;
    end
    chk("post_rst_granted", seen, 1);
    chk("post_rst_owner", owner, 0);
    wait_idle(4000);
    chk("post_rst_jobs_done", jobs_done, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
